// File: rtl/tail_anim_ctrl.sv
// Plasma-tail sprite sequencer: paces the 4-frame animation against video frames
// and turns the scan position plus ROM row data into a registered pixel_on.
module tail_anim_ctrl #(
    parameter int X_W = 10,
    parameter int Y_W = 10,
    parameter int DIV = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           frame_start,
    input  logic           thrust,
    input  logic [X_W-1:0] ship_x,
    input  logic [Y_W-1:0] ship_y,
    input  logic [X_W-1:0] px,
    input  logic [Y_W-1:0] py,
    input  logic           px_valid,
    output logic [3:0]     rom_y,
    output logic [1:0]     rom_frame,
    input  logic [15:0]    rom_bits,
    output logic           pixel_on,
    output logic           tail_active
);

    // state  | meaning
    // OFF    | engine off, nothing drawn
    // IGNITE | playing start-up frames 0,1,2
    // BURN   | looping frames 3,1,2
    // COOL   | engine cut, frame 0 shown for one animation step
    typedef enum logic [1:0] {OFF, IGNITE, BURN, COOL} state_t;

    localparam logic [3:0] DIV_LAST = 4'(DIV - 1);
    localparam logic [X_W:0] BOX_X = (X_W+1)'(16);
    localparam logic [Y_W:0] BOX_Y = (Y_W+1)'(16);

    state_t         state, state_nx;
    logic [1:0]     frame, frame_nx;
    logic [3:0]     div_cnt, div_nx;
    logic           step;
    logic [X_W-1:0] tx;
    logic [Y_W-1:0] ty;
    logic [X_W:0]   dx;
    logic [Y_W:0]   dy;
    logic [3:0]     col;
    logic           hit;
    logic           pix_bit;

    // One extra bit keeps px < tx from aliasing into the box near the right edge.
    assign dx  = {1'b0, px} - {1'b0, tx};
    assign dy  = {1'b0, py} - {1'b0, ty};
    assign col = dx[3:0];
    assign hit = px_valid && (px >= tx) && (dx < BOX_X) && (py >= ty) && (dy < BOX_Y);
    assign pix_bit = rom_bits[4'd15 - col];

    assign rom_y       = dy[3:0];
    assign rom_frame   = frame;
    assign tail_active = (state != OFF);
    assign step        = (div_cnt == DIV_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= OFF;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        frame_nx = frame;
        div_nx   = div_cnt;
        if (frame_start) begin
            div_nx = step ? 4'd0 : div_cnt + 4'd1;
            case (state)
                OFF: begin
                    frame_nx = 2'd0;
                    if (thrust) begin
                        state_nx = IGNITE;
                        div_nx   = 4'd0;
                    end
                end
                IGNITE: begin
                    if (!thrust) begin
                        state_nx = COOL;
                        frame_nx = 2'd0;
                        div_nx   = 4'd0;
                    end else if (step) begin
                        if (frame == 2'd2) begin
                            state_nx = BURN;
                            frame_nx = 2'd3;
                        end else begin
                            frame_nx = frame + 2'd1;
                        end
                    end
                end
                BURN: begin
                    if (!thrust) begin
                        state_nx = COOL;
                        frame_nx = 2'd0;
                        div_nx   = 4'd0;
                    end else if (step) begin
                        frame_nx = (frame == 2'd3) ? 2'd1 : frame + 2'd1;
                    end
                end
                COOL: begin
                    frame_nx = 2'd0;
                    if (thrust) begin
                        state_nx = IGNITE;
                        div_nx   = 4'd0;
                    end else if (step) begin
                        state_nx = OFF;
                    end
                end
                default: begin
                    state_nx = OFF;
                    frame_nx = 2'd0;
                    div_nx   = 4'd0;
                end
            endcase
        end
    end

    // The pixel register sees the pre-edge state/position, so a pixel coinciding
    // with frame_start still uses the previous frame's values.
    always_ff @(posedge clk) begin
        if (rst) begin
            frame    <= 2'd0;
            div_cnt  <= 4'd0;
            tx       <= '0;
            ty       <= '0;
            pixel_on <= 1'b0;
        end else begin
            frame    <= frame_nx;
            div_cnt  <= div_nx;
            pixel_on <= hit && pix_bit && (state != OFF);
            if (frame_start) begin
                tx <= ship_x;
                ty <= ship_y;
            end
        end
    end

endmodule

// File: tb/tb_tail_anim_ctrl.sv
// Directed bench for tail_anim_ctrl with DIV=2 and a small behavioural sprite ROM.
module tb_tail_anim_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        frame_start = 1'b0;
    logic        thrust = 1'b0;
    logic [9:0]  ship_x = '0;
    logic [9:0]  ship_y = '0;
    logic [9:0]  px = '0;
    logic [9:0]  py = '0;
    logic        px_valid = 1'b0;
    logic [3:0]  rom_y;
    logic [1:0]  rom_frame;
    logic [15:0] rom_bits;
    logic        pixel_on;
    logic        tail_active;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    tail_anim_ctrl #(.X_W(10), .Y_W(10), .DIV(2)) dut (
        .clk(clk), .rst(rst), .frame_start(frame_start), .thrust(thrust),
        .ship_x(ship_x), .ship_y(ship_y), .px(px), .py(py), .px_valid(px_valid),
        .rom_y(rom_y), .rom_frame(rom_frame), .rom_bits(rom_bits),
        .pixel_on(pixel_on), .tail_active(tail_active)
    );

    // Row 7 of frames 0 and 3 has distinctive patterns; everything else is solid.
    always_comb begin
        rom_bits = 16'hFFFF;
        if (rom_frame == 2'd0 && rom_y == 4'd7) rom_bits = 16'h00FF;
        if (rom_frame == 2'd3 && rom_y == 4'd7) rom_bits = 16'h0FFF;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fs();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        tick();
    endtask

    task automatic scan(input string tag, input int row, input int lo, input int hi,
                        input int lit_lo, input int lit_hi);
        for (int x = lo; x <= hi; x++) begin
            px = x[9:0];
            py = row[9:0];
            px_valid = 1'b1;
            tick();
            chk(tag, 32'(pixel_on), (x >= lit_lo && x <= lit_hi) ? 32'd1 : 32'd0);
        end
        px_valid = 1'b0;
        tick();
    endtask

    int seq[13] = '{0, 0, 1, 1, 2, 2, 3, 3, 1, 1, 2, 2, 3};

    initial begin
        tick();
        tick();
        rst = 1'b0;
        chk("rst_frame", 32'(rom_frame), 32'd0);
        chk("rst_active", 32'(tail_active), 32'd0);
        chk("rst_pixel", 32'(pixel_on), 32'd0);

        thrust = 1'b1;
        for (int i = 0; i < 13; i++) begin
            fs();
            chk("frame_seq", 32'(rom_frame), 32'(seq[i]));
            chk("seq_active", 32'(tail_active), 32'd1);
        end

        // Enter COOL and latch the box at (100,50) on the same pulse.
        thrust = 1'b0;
        ship_x = 10'd100;
        ship_y = 10'd50;
        fs();
        chk("cool_frame", 32'(rom_frame), 32'd0);
        chk("cool_active", 32'(tail_active), 32'd1);
        scan("row7_win", 57, 96, 120, 108, 115);

        ship_x = 10'd200;
        scan("midframe_hold", 57, 96, 120, 108, 115);

        px = 10'd110;
        py = 10'd57;
        px_valid = 1'b1;
        frame_start = 1'b1;
        tick();
        chk("fs_old_tx", 32'(pixel_on), 32'd1);
        frame_start = 1'b0;
        px_valid = 1'b0;
        tick();
        chk("cool_hold", 32'(tail_active), 32'd1);
        scan("new_win", 57, 196, 220, 208, 215);
        scan("old_win_gone", 57, 104, 118, 1, 0);

        thrust = 1'b1;
        fs();
        chk("reign_frame", 32'(rom_frame), 32'd0);
        chk("reign_active", 32'(tail_active), 32'd1);
        fs();
        fs();
        chk("reign_step", 32'(rom_frame), 32'd1);

        thrust = 1'b0;
        fs();
        chk("cool2_frame", 32'(rom_frame), 32'd0);
        thrust = 1'b1;
        tick();
        tick();
        tick();
        thrust = 1'b0;
        fs();
        chk("cool2_mid", 32'(tail_active), 32'd1);
        fs();
        chk("off_active", 32'(tail_active), 32'd0);
        chk("off_frame", 32'(rom_frame), 32'd0);
        scan("off_dark", 57, 200, 220, 1, 0);

        ship_x = 10'd1020;
        ship_y = 10'd0;
        thrust = 1'b1;
        for (int i = 0; i < 7; i++) fs();
        chk("edge_frame", 32'(rom_frame), 32'd3);
        scan("edge_row7", 7, 0, 1023, 1, 0);
        scan("edge_row6", 6, 1010, 1023, 1020, 1023);
        scan("edge_nowrap", 6, 0, 8, 1, 0);

        px = 10'd1021;
        py = 10'd6;
        px_valid = 1'b1;
        frame_start = 1'b1;
        rst = 1'b1;
        tick();
        chk("rst_burn_pixel", 32'(pixel_on), 32'd0);
        chk("rst_burn_frame", 32'(rom_frame), 32'd0);
        chk("rst_burn_active", 32'(tail_active), 32'd0);
        rst = 1'b0;
        frame_start = 1'b0;
        px_valid = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
